// File: rtl/m163_d16_digit_mul.sv
// Digit-serial (16-bit digit, MSB first) multiplier in GF(2^163), f(x) = x^163+x^7+x^6+x^3+1.
// Optional output register stage on c_out/done: define M163_D16_OUT_REG_EN.
module m163_d16_digit_mul (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [162:0] a_in,
  input  logic [162:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [162:0] c_out,
  output logic [14:0]  ovf_out
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepted edge
  // RUN   | one 16-bit digit of B per edge, counter 10 down to 0
  // DONE  | result valid, done pulse, back to IDLE next edge
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_DIGIT = 4'd10;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [162:0] a_q, a_d;
  logic [175:0] b_q, b_d;
  logic [162:0] c_q, c_d;
  logic [162:0] res_q, res_d;
  logic [14:0]  ovf_q, ovf_d;
  logic         busy_c, done_c;

  logic [15:0]  digit;
  logic [177:0] prod;
  logic [15:0]  t;
  logic [22:0]  fold_t;
  logic [14:0]  h;
  logic [21:0]  fold_h;
  logic [162:0] c_next;

  always_comb begin : digit_sel
    digit = '0;
    for (int i = 0; i < 11; i++) begin
      if (cnt_q == 4'(i)) digit = b_q[16*i +: 16];
    end
  end

  always_comb begin : clmul
    prod = '0;
    for (int j = 0; j < 16; j++) begin
      if (digit[j]) prod = prod ^ ({15'b0, a_q} << j);
    end
  end

  // Both folds use x^163 = x^7+x^6+x^3+1; neither fold reaches bit 163 again.
  always_comb begin : reduce
    t      = c_q[162:147];
    fold_t = {7'b0, t} ^ {4'b0, t, 3'b0} ^ {1'b0, t, 6'b0} ^ {t, 7'b0};
    h      = prod[177:163];
    fold_h = {7'b0, h} ^ {4'b0, h, 3'b0} ^ {1'b0, h, 6'b0} ^ {h, 7'b0};
    c_next = {c_q[146:0], 16'b0} ^ {140'b0, fold_t} ^ {141'b0, fold_h} ^ prod[162:0];
  end

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = {13'b0, b_in};
          c_d     = '0;
          cnt_d   = LAST_DIGIT;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        c_d    = c_next;
        ovf_d  = h;
        if (cnt_q == 4'd0) begin
          res_d   = c_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      res_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign busy    = busy_c;
  assign ovf_out = ovf_q;

`ifdef M163_D16_OUT_REG_EN
  logic         done_r_q;
  logic [162:0] cout_r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_r_q <= 1'b0;
      cout_r_q <= '0;
    end else begin
      done_r_q <= done_c;
      cout_r_q <= res_q;
    end
  end

  assign done  = done_r_q;
  assign c_out = cout_r_q;
`else
  assign done  = done_c;
  assign c_out = res_q;
`endif

endmodule

// File: tb/tb_m163_d16_digit_mul.sv
// Scoreboard bench for m163_d16_digit_mul: driver pushes expected results, negedge monitor pops on done.
module tb_m163_d16_digit_mul;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [162:0] a_in = '0;
  logic [162:0] b_in = '0;
  logic         busy, done;
  logic [162:0] c_out;
  logic [14:0]  ovf_out;

  m163_d16_digit_mul dut (
    .clk(clk), .rstn(rstn), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .c_out(c_out), .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

`ifdef M163_D16_OUT_REG_EN
  localparam int LAT = 12;
  localparam int SPACING = 14;
`else
  localparam int LAT = 11;
  localparam int SPACING = 13;
`endif

  typedef struct {
    logic [162:0] c;
    logic         chk_ovf;
    logic [14:0]  ovf;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic b2b = 1'b0;
  int   prev_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial reference: Horner over B, MSB first.
  function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
    logic [162:0] r;
    logic         msb;
    r = '0;
    for (int i = 162; i >= 0; i--) begin
      msb = r[162];
      r   = r << 1;
      if (msb) r = r ^ 163'hC9;
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return v[162:0];
  endfunction

  task automatic check(input string name, input logic [162:0] act, input logic [162:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    if (busy && done) begin
      n_fail++;
      $display("FAIL busy_done_overlap: busy=1 done=1 expected not both (cycle %0d)", cyc);
    end
    if (done) begin
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("c_out", c_out, mon_e.c);
        if (mon_e.chk_ovf) check("ovf_out", 163'(ovf_out), 163'(mon_e.ovf));
        check("latency", 163'(cyc - mon_e.start_cyc), 163'(LAT));
        if (b2b) begin
          if (prev_done >= 0) check("done_spacing", 163'(cyc - prev_done), 163'(SPACING));
          prev_done = cyc;
        end
      end
    end
  end

  task automatic push_exp(input logic [162:0] c, input logic chk, input logic [14:0] ov);
    exp_t e;
    e.c = c;
    e.chk_ovf = chk;
    e.ovf = ov;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [162:0] a, input logic [162:0] b, input logic [162:0] exp_c,
                       input logic chk, input logic [14:0] ov);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    push_exp(exp_c, chk, ov);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_fail++;
    $display("FAIL timeout: got no done within 40 cycles expected done");
  endtask

  logic [162:0] ta, tb_v, ones, x162;

  initial begin
    ones = '1;
    x162 = '0;
    x162[162] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 163'(busy), 163'(0));
    check("rst_done", 163'(done), 163'(0));
    check("rst_c_out", c_out, 163'(0));
    check("rst_ovf", 163'(ovf_out), 163'(0));
    @(negedge clk) rstn = 1'b1;

    // 1 * 1 = 1
    issue(163'd1, 163'd1, 163'd1, 1'b1, 15'd0);
    @(negedge clk);
    check("busy_in_run", 163'(busy), 163'(1));
    check("done_in_run", 163'(done), 163'(0));
    wait_done();

    // x^162 * x = x^163 = x^7+x^6+x^3+1; the single overflow bit is bit 163
    issue(x162, 163'h2, 163'hC9, 1'b1, 15'd1);
    wait_done();

    // (x+1)(x^2+1) = x^3+x^2+x+1, no reduction
    issue(163'h3, 163'h5, 163'hF, 1'b1, 15'd0);
    wait_done();

    // identity on a sparse operand
    issue(163'h1234_0000_0000_0000_0001, 163'd1, 163'h1234_0000_0000_0000_0001, 1'b1, 15'd0);
    wait_done();

    // all-ones * x^15: every top bit of A lands in 177..163 on the digit-0 edge
    issue(ones, 163'h8000, gf_mul(ones, 163'h8000), 1'b1, 15'h7FFF);
    wait_done();
    repeat (3) @(negedge clk);
    check("ovf_hold", 163'(ovf_out), 163'h7FFF);
    check("c_out_hold", c_out, gf_mul(ones, 163'h8000));

    issue(x162, x162, gf_mul(x162, x162), 1'b0, 15'd0);
    wait_done();

    // start held through RUN and DONE with operands changed mid-run
    ta = rand163();
    tb_v = rand163();
    @(negedge clk);
    a_in  = ta;
    b_in  = tb_v;
    start = 1'b1;
    push_exp(gf_mul(ta, tb_v), 1'b0, 15'd0);
    repeat (4) @(negedge clk);
    a_in = rand163();
    b_in = rand163();
    wait_done();
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("idle_after_hold", 163'(busy), 163'(0));

    // reset at RUN edge 5 aborts the operation
    issue(rand163(), rand163(), 163'd0, 1'b0, 15'd0);
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_busy", 163'(busy), 163'(0));
    check("abort_done", 163'(done), 163'(0));
    check("abort_c_out", c_out, 163'(0));
    check("abort_ovf", 163'(ovf_out), 163'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    ta = rand163();
    tb_v = rand163();
    issue(ta, tb_v, gf_mul(ta, tb_v), 1'b0, 15'd0);
    wait_done();

    b2b = 1'b1;
    prev_done = -1;
    for (int i = 0; i < 1000; i++) begin
      ta = rand163();
      tb_v = rand163();
      issue(ta, tb_v, gf_mul(ta, tb_v), 1'b0, 15'd0);
      wait_done();
    end
    b2b = 1'b0;

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 163'(sb.size()), 163'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m163_d16_digit_mul.md
M163_D16_DIGIT_MUL -- requirements
Module: m163_d16_digit_mul

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-004 SHALL have port a_in, input, 163 bits: operand A, captured on the accepted start edge.
REQ-005 SHALL have port b_in, input, 163 bits: operand B, captured on the accepted start edge.
REQ-006 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse when c_out holds a new result.
REQ-008 SHALL have port c_out, output, 163 bits: product A*B mod f(x), with f(x) = x^163+x^7+x^6+x^3+1.
REQ-009 SHALL have port ovf_out, output, 15 bits: unreduced bits 177..163 of A*d for the current digit d, registered, for the downstream 15-bit overflow register.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE, on an edge with start=1, SHALL capture a_in and b_in, clear the accumulator C, set the digit counter to 10 and enter RUN.
REQ-012 SHALL zero-pad B to 176 bits (11 digits of 16 bits); digit i = B[16i+15:16i]; digits are processed MSB first, i = 10 down to 0.
REQ-013 On each RUN edge SHALL compute C <= (C*x^16 mod f) XOR (A*d_i mod f) using carry-less (GF(2)) arithmetic, then decrement the counter.
REQ-014 Reduction of C*x^16: the top 16 bits t SHALL be folded back as t*(x^7+x^6+x^3+1) into bits 22..0.
REQ-015 Reduction of A*d_i (178 bits): the top 15 bits h SHALL be folded back as h*(x^7+x^6+x^3+1) into bits 21..0.
REQ-016 ovf_out SHALL be updated to h on every RUN edge and hold its value otherwise.
REQ-017 After the RUN edge that processes counter=0 the block SHALL enter DONE; total RUN edges = 11.
REQ-018 Latency: start accepted at edge k gives done=1 and a valid c_out after edge k+11.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE on the next edge.
REQ-020 c_out SHALL hold the last result until the next completion.
REQ-021 start SHALL be ignored in RUN and DONE; the operands SHALL NOT be recaptured.
REQ-022 busy SHALL be 1 exactly in RUN; done and busy SHALL never both be 1.
REQ-023 Back-to-back operation: start asserted in the IDLE cycle directly after DONE SHALL be accepted with no extra gap.

Reset
REQ-024 rstn=0 SHALL force, asynchronously: FSM=IDLE, counter=0, C=0, A=0, B=0, c_out=0, ovf_out=0, busy=0, done=0.
REQ-025 Reset during RUN SHALL abort the multiplication with no done pulse; the first start after rstn rises SHALL be accepted normally.

Configuration
REQ-026 Macro M163_D16_OUT_REG_EN defined: c_out and done SHALL pass through one extra register stage (latency k+12, done still one cycle wide, stage reset to 0).
REQ-027 Macro M163_D16_OUT_REG_EN undefined: c_out and done SHALL be driven directly from the FSM/accumulator with the latency of REQ-018.

Verification
REQ-028 a_in=1, b_in=1, start pulse -> done after 11 RUN edges, c_out=1, ovf_out=0.
REQ-029 a_in=x^162, b_in=x (0x2) -> c_out=0xC9 (x^7+x^6+x^3+1).
REQ-030 a_in=all ones, b_in=x^15 (0x8000) -> ovf_out=0x7FFF on the digit-0 edge; c_out equals the software model.
REQ-031 1000 random A,B pairs issued back-to-back -> every c_out matches the GF(2^163) reference model; done spacing = 13 cycles.
REQ-032 start held high through RUN and DONE -> exactly one result per accepted start; operands change mid-RUN without affecting c_out.
REQ-033 rstn pulsed low at RUN edge 5 -> all outputs 0 immediately, no done; next start gives the correct product.
